// File: rtl/uart_input_protocol_controller.sv
// uart_input_protocol_controller
//   Turns a byte stream from a UART receiver into accelerator control actions
//   and FIFO writes. Command bytes seen while idle:
//     0x00 SW_RESET : 16-cycle sw_rst pulse, clears start and the error flags
//     0x01 START    : raises the start level (held until reset)
//     0x02 DATA     : followed by channel byte, count byte (0 = 256 words) and
//                     count*BYTES data bytes, assembled little-endian into words
//   Any other byte received while idle is ignored.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   rx_data/valid   : received byte and its one-cycle qualifier
//   in_fifo_full    : per-FIFO full flags
//   in_fifo_we      : one-hot FIFO write enables
//   in_fifo_data    : word presented to all FIFOs
//   sw_rst, start   : accelerator software reset pulse / start level
//   busy            : controller is not idle
//   err_ch, err_ovf : sticky flags for a bad channel index / byte lost while stalled
module uart_input_protocol_controller #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [NUM_INPUTS-1:0] in_fifo_full,
  output logic [NUM_INPUTS-1:0] in_fifo_we,
  output logic [DATA_WIDTH-1:0] in_fifo_data,
  output logic                  sw_rst,
  output logic                  start,
  output logic                  busy,
  output logic                  err_ch,
  output logic                  err_ovf
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CH_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE    = BI_W'(BYTES - 1);
  localparam logic [7:0]      NUM_INPUTS_B = 8'(NUM_INPUTS);
  localparam logic [7:0]      CMD_SW_RESET = 8'h00;
  localparam logic [7:0]      CMD_START    = 8'h01;
  localparam logic [7:0]      CMD_DATA     = 8'h02;

  typedef enum logic [2:0] {
    IDLE, RST_PULSE, GET_CH, GET_CNT, GET_DATA, WAIT_FULL
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            pulse_cnt_q, pulse_cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  ch_ok_q, ch_ok_d;
  logic [7:0]            cnt_q, cnt_d;          // word count byte, 0 encodes 256
  logic [7:0]            word_idx_q, word_idx_d;
  logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_INPUTS-1:0] we_q, we_d;
  logic                  sw_rst_q, sw_rst_d;
  logic                  start_q, start_d;
  logic                  err_ch_q, err_ch_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [NUM_INPUTS-1:0] ch_sel;      // one-hot target, all-zero for a bad channel
  logic [DATA_WIDTH-1:0] word_asm;    // word_q with the incoming byte merged in
  logic                  tgt_full;
  logic                  last_word;
  logic                  drain_we;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_sel
      assign ch_sel[gi] = ch_ok_q && (ch_q == CH_W'(gi));
    end
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_asm
      assign word_asm[gi*8 +: 8] = (byte_idx_q == BI_W'(gi)) ? rx_data : word_q[gi*8 +: 8];
    end
  endgenerate

  assign tgt_full = |(in_fifo_full & ch_sel);
  // cnt_q - 1 wraps 0 to 255, so a count byte of 0 naturally yields 256 words.
  assign last_word = (word_idx_q == cnt_q - 8'd1);
  // A stalled word is written in the very cycle its FIFO reports not-full.
  assign drain_we = (state_q == WAIT_FULL) && !tgt_full;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    ch_d        = ch_q;
    ch_ok_d     = ch_ok_q;
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    data_d      = data_q;
    we_d        = '0;
    sw_rst_d    = sw_rst_q;
    start_d     = start_q;
    err_ch_d    = err_ch_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_SW_RESET: begin
              state_d     = RST_PULSE;
              sw_rst_d    = 1'b1;
              pulse_cnt_d = '0;
              start_d     = 1'b0;
              err_ch_d    = 1'b0;
              err_ovf_d   = 1'b0;
            end
            CMD_START: start_d = 1'b1;
            CMD_DATA:  state_d = GET_CH;
            default:   state_d = IDLE;
          endcase
        end
      end
      RST_PULSE: begin
        // Incoming bytes are deliberately ignored here.
        pulse_cnt_d = pulse_cnt_q + 4'd1;
        if (pulse_cnt_q == 4'd15) begin
          sw_rst_d = 1'b0;
          state_d  = IDLE;
        end
      end
      GET_CH: begin
        if (rx_valid) begin
          ch_d    = rx_data[CH_W-1:0];
          ch_ok_d = (rx_data < NUM_INPUTS_B);
          if (rx_data >= NUM_INPUTS_B) err_ch_d = 1'b1;
          state_d = GET_CNT;
        end
      end
      GET_CNT: begin
        if (rx_valid) begin
          cnt_d      = rx_data;
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = GET_DATA;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          word_d = word_asm;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (ch_ok_q) data_d = word_asm;
            if (tgt_full) begin
              state_d = WAIT_FULL;
            end else begin
              // ch_sel is zero for a bad channel, so that frame is only consumed.
              we_d = ch_sel;
              if (last_word) state_d = IDLE;
              else           word_idx_d = word_idx_q + 8'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      WAIT_FULL: begin
        if (rx_valid) err_ovf_d = 1'b1;
        if (!tgt_full) begin
          if (last_word) begin
            state_d = IDLE;
          end else begin
            word_idx_d = word_idx_q + 8'd1;
            state_d    = GET_DATA;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      data_q      <= '0;
      we_q        <= '0;
      sw_rst_q    <= 1'b0;
      start_q     <= 1'b0;
      err_ch_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      ch_q        <= ch_d;
      ch_ok_q     <= ch_ok_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      data_q      <= data_d;
      we_q        <= we_d;
      sw_rst_q    <= sw_rst_d;
      start_q     <= start_d;
      err_ch_q    <= err_ch_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign in_fifo_we   = we_q | (drain_we ? ch_sel : '0);
  assign in_fifo_data = data_q;
  assign sw_rst       = sw_rst_q;
  assign start        = start_q;
  assign busy         = (state_q != IDLE);
  assign err_ch       = err_ch_q;
  assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_uart_input_protocol_controller.sv
// Bench for uart_input_protocol_controller (NUM_INPUTS=2, DATA_WIDTH=32).
// Stimulus pushes the words each frame should produce into a queue; a monitor
// process pops and compares on every FIFO write. Directed scenarios are
// followed by randomized frames, commands, stalls and overflow pokes.
module tb_uart_input_protocol_controller;
  localparam int NI = 2;
  localparam int DW = 32;
  localparam int BY = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NI-1:0] in_fifo_full;
  logic [NI-1:0] in_fifo_we;
  logic [DW-1:0] in_fifo_data;
  logic          sw_rst, start, busy, err_ch, err_ovf;

  uart_input_protocol_controller #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .in_fifo_full(in_fifo_full), .in_fifo_we(in_fifo_we), .in_fifo_data(in_fifo_data),
    .sw_rst(sw_rst), .start(start), .busy(busy), .err_ch(err_ch), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_err_ch = 0, exp_err_ovf = 0, exp_start = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the queue and
  // land on a FIFO that is not full in that cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   ch;
    if (in_fifo_we !== '0) begin
      vectors++;
      ch = -1;
      for (int i = 0; i < NI; i++) if (in_fifo_we[i] === 1'b1) ch = i;
      if ($countones(in_fifo_we) != 1) begin
        miscompares++;
        $display("FAIL we_onehot: got %b, wanted a single bit", in_fifo_we);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got ch=%0d data=0x%08h, wanted no write", ch, in_fifo_data);
      end else begin
        e = exp_q.pop_front();
        if (ch != e.ch || in_fifo_data !== e.data || in_fifo_full[ch] !== 1'b0) begin
          miscompares++;
          $display("FAIL write: got ch=%0d data=0x%08h full=%b, wanted ch=%0d data=0x%08h full=0",
                   ch, in_fifo_data, in_fifo_full[ch], e.ch, e.data);
        end else begin
          $display("write ch=%0d data=0x%08h", ch, in_fifo_data);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Byte occupies the current cycle; returns one cycle later at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic logic [DW-1:0] le_word(input logic [7:0] b [$], input int base);
    logic [DW-1:0] w = '0;
    for (int k = 0; k < BY; k++) w = w + (DW'(b[base + k]) << (8 * k));
    return w;
  endfunction

  task automatic send_frame(input int ch, input int cnt, input int stall_word,
                            input int stall_cyc, input bit poke, input int max_gap);
    int words = (cnt == 0) ? 256 : cnt;
    logic [7:0] bytes [$];
    bit stalled;
    for (int i = 0; i < words * BY; i++) bytes.push_back(8'($urandom));
    if (ch < NI) begin
      for (int w = 0; w < words; w++) exp_q.push_back('{ch, le_word(bytes, w * BY)});
    end else begin
      exp_err_ch = 1'b1;
    end
    send_byte(8'h02);
    idle($urandom_range(0, max_gap));
    send_byte(8'(ch));
    send_byte(8'(cnt));
    for (int w = 0; w < words; w++) begin
      stalled = (w == stall_word) && (ch < NI);
      for (int k = 0; k < BY; k++) begin
        if (stalled && k == BY - 1) in_fifo_full[ch] = 1'b1;
        send_byte(bytes[w * BY + k]);
        if (k != BY - 1) idle($urandom_range(0, max_gap));
      end
      if (stalled) begin
        if (poke) begin
          send_byte(8'($urandom));
          exp_err_ovf = 1'b1;
        end
        idle(stall_cyc);
        in_fifo_full[ch] = 1'b0;
        idle(1);
      end else begin
        idle($urandom_range(0, max_gap));
      end
    end
    idle(2);
  endtask

  task automatic post_checks(input string tag);
    @(negedge clk);
    check({tag, "_busy"},    DW'(busy),        '0);
    check({tag, "_err_ch"},  DW'(err_ch),      DW'(exp_err_ch));
    check({tag, "_err_ovf"}, DW'(err_ovf),     DW'(exp_err_ovf));
    check({tag, "_start"},   DW'(start),       DW'(exp_start));
    check({tag, "_pending"}, DW'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    exp_err_ch = 0; exp_err_ovf = 0; exp_start = 0;
  endtask

  initial begin : stim
    int hi;
    int r, ch, cnt;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; in_fifo_full = '0;
    idle(3);
    @(negedge clk);
    check("rst_we",      DW'(in_fifo_we), '0);
    check("rst_data",    in_fifo_data,    '0);
    check("rst_sw_rst",  DW'(sw_rst),     '0);
    check("rst_start",   DW'(start),      '0);
    check("rst_busy",    DW'(busy),       '0);
    check("rst_err_ch",  DW'(err_ch),     '0);
    check("rst_err_ovf", DW'(err_ovf),    '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single word to channel 1; write appears the cycle after the last byte.
    exp_q.push_back('{1, 32'h11223344});
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    @(negedge clk);
    check("r031_we",   DW'(in_fifo_we), DW'(2'b10));
    check("r031_data", in_fifo_data,    32'h11223344);
    @(posedge clk); #1;
    post_checks("r031");

    // Non-command byte in idle is ignored.
    send_byte(8'h7E);
    @(negedge clk);
    check("ignore_busy", DW'(busy), '0);
    @(posedge clk); #1;

    // START then SW_RESET.
    send_byte(8'h01);
    @(negedge clk);
    check("r032_start", DW'(start), 1);
    @(posedge clk); #1;
    send_byte(8'h01);
    send_byte(8'h00);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("r032_start_clr", DW'(start), '0);
        check("r032_busy",      DW'(busy),  1);
      end
      if (sw_rst === 1'b1) hi++;
      else break;
    end
    check("r032_sw_rst_len", DW'(hi), 16);
    @(posedge clk); #1;
    clear_model();
    post_checks("r032");

    // Bytes arriving during the reset pulse are dropped without error.
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
    idle(20);
    post_checks("pulse_drop");

    // Stall on the first word for five cycles, then a normal second word.
    send_frame(0, 2, 0, 4, 0, 0);
    post_checks("r033");

    // Byte sent while stalled is dropped and flags overflow until SW_RESET.
    send_frame(1, 2, 0, 3, 1, 1);
    post_checks("r034");
    send_byte(8'h00); idle(20);
    clear_model();
    post_checks("r034_clr");

    // Bad channel: bytes consumed, no write, idle right after the last byte.
    exp_err_ch = 1'b1;
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h01);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    @(negedge clk);
    check("r035_busy",   DW'(busy),   '0);
    check("r035_err_ch", DW'(err_ch), 1);
    @(posedge clk); #1;
    idle(2);
    post_checks("r035");

    // Reset mid-frame, then a fresh frame.
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h66);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("r036_abort_busy", DW'(busy), '0);
    @(posedge clk); #1;
    send_frame(0, 1, -1, 0, 0, 0);
    post_checks("r036");

    // Reset during the sw_rst pulse drops it on the next cycle.
    send_byte(8'h00);
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_pulse", DW'(sw_rst), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Randomized mix of frames, commands, stalls and overflow pokes.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_byte(8'h01);
        exp_start = 1'b1;
        idle(1);
      end else if (r == 1) begin
        send_byte(8'h00);
        idle(20);
        clear_model();
      end else begin
        ch  = $urandom_range(0, NI);
        cnt = $urandom_range(1, 3);
        for (int i = 0; i < NI; i++) if (i != ch) in_fifo_full[i] = 1'($urandom_range(0, 1));
        send_frame(ch, cnt,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1,
                   $urandom_range(0, 6), ($urandom_range(0, 4) == 0), 2);
        in_fifo_full = '0;
      end
      post_checks("rand");
    end

    // Count byte 0 means 256 words.
    send_frame(0, 0, 100, 2, 0, 0);
    post_checks("cnt256");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_input_protocol_controller.md
UART_INPUT_PROTOCOL_CONTROLLER -- requirements
Module: uart_input_protocol_controller

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of accelerator input FIFOs (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: accelerator word width; a multiple of 8, at least 8; BYTES = DATA_WIDTH/8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset; driven from the board button only, never from sw_rst.
REQ-005 SHALL have port rx_data, input, 8: byte from UART receiver.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port in_fifo_full, input, NUM_INPUTS: per-FIFO full flags.
REQ-008 SHALL have port in_fifo_we, output, NUM_INPUTS: one-hot write enables.
REQ-009 SHALL have port in_fifo_data, output, DATA_WIDTH: word shared by all FIFOs.
REQ-010 SHALL have port sw_rst, output, 1: software reset pulse to the accelerator and FIFOs.
REQ-011 SHALL have port start, output, 1: accelerator start level.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port err_ch, output, 1: sticky, bad channel index received.
REQ-014 SHALL have port err_ovf, output, 1: sticky, byte dropped while stalled on a full FIFO.

Function
REQ-015 SHALL decode, in IDLE, command bytes: 0x00 = SW_RESET, 0x01 = START, 0x02 = DATA; any other byte is ignored and the FSM stays in IDLE.
REQ-016 SHALL use states IDLE, RST_PULSE, GET_CH, GET_CNT, GET_DATA, WAIT_FULL.
REQ-017 SHALL, on SW_RESET, enter RST_PULSE, hold sw_rst high for exactly 16 cycles, clear start, err_ch and err_ovf, then return to IDLE; rx_valid bytes arriving in RST_PULSE are dropped without setting err_ovf.
REQ-018 SHALL, on START, set start to 1 on the cycle after the rx_valid and hold it until rst or SW_RESET; a repeated START has no further effect.
REQ-019 SHALL, on DATA, enter GET_CH; the next byte is the channel index; GET_CNT follows.
REQ-020 SHALL treat the GET_CNT byte as the word count N, where 0 means 256; the FSM then enters GET_DATA.
REQ-021 SHALL assemble each word little-endian: the first byte goes to bits [7:0], and the BYTES-th byte completes the word.
REQ-022 SHALL, on word completion with the target not full, pulse in_fifo_we[ch] for one cycle on the cycle after the final byte's rx_valid, with in_fifo_data stable that cycle.
REQ-023 SHALL, on word completion with in_fifo_full[ch]=1, enter WAIT_FULL, hold the word, and issue the write on the first cycle in_fifo_full[ch]=0; the FSM then resumes GET_DATA, or enters IDLE if that was word N.
REQ-024 SHALL drop any rx_valid byte arriving in WAIT_FULL and set err_ovf.
REQ-025 SHALL, if channel index >= NUM_INPUTS, set err_ch, still consume the count and N*BYTES data bytes, and issue no writes for that frame.
REQ-026 SHALL return to IDLE one cycle after the last word of a frame is written or discarded.
REQ-027 SHALL keep in_fifo_we all-zero outside the write cycles; at most one bit of in_fifo_we is high per cycle.
REQ-028 SHALL keep the byte and word counters sized for BYTES and 256 respectively, with no wrap within a frame.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state to IDLE, in_fifo_we=0, in_fifo_data=0, sw_rst=0, start=0, busy=0, err_ch=0, err_ovf=0, and clear all counters.
REQ-030 SHALL, when rst is asserted mid-frame or mid-pulse, abandon the frame, write no partial word, and deassert sw_rst on the next cycle.

Verification
REQ-031 SHALL pass: bytes 02 01 01 44 33 22 11 (NUM_INPUTS=2, DATA_WIDTH=32) -> single in_fifo_we=2'b10 pulse with in_fifo_data=0x11223344, then busy=0.
REQ-032 SHALL pass: byte 01, then byte 00 -> start=1 from the cycle after the first byte; after the second byte, sw_rst is high for exactly 16 cycles and start=0.
REQ-033 SHALL pass: frame 02 00 02 + 8 data bytes with in_fifo_full[0]=1 during the first word for 5 cycles -> first write waits until full drops, second word is written normally, err_ovf=0.
REQ-034 SHALL pass: a byte sent during WAIT_FULL -> byte dropped, err_ovf=1 until SW_RESET or rst.
REQ-035 SHALL pass: frame 02 05 01 + 4 bytes -> err_ch=1, in_fifo_we never asserted, FSM back in IDLE after the fourth data byte.
REQ-036 SHALL pass: rst asserted after 2 of 4 data bytes, then a fresh full frame -> no write from the aborted frame; the fresh frame's word is written correctly.
